// File: rtl/pcs_pkg.sv
// Shared 10GBASE-R PCS constants used by the gearbox, receive block-sync and benches.
package pcs_pkg;
  localparam int HEAD_W  = 2;
  localparam int DATA_W  = 64;
  localparam int BLOCK_W = HEAD_W + DATA_W;

  localparam logic [HEAD_W-1:0] SYNC_DATA = 2'b01;
  localparam logic [HEAD_W-1:0] SYNC_CTRL = 2'b10;

  localparam int                  GB_SEQ_W   = 6;
  localparam logic [GB_SEQ_W-1:0] GB_SEQ_MAX = 6'd32;
endpackage

// File: rtl/gearbox_tx.sv
// 66b->64b transmit gearbox: one-cycle registered latency, 32 blocks become 33 words.
// Backpressure: accept_o drops (from the seq register only) for one enabled cycle in 33.
module gearbox_tx
  import pcs_pkg::*;
(
  input  logic              clk,
  input  logic              nreset,
  input  logic              valid_i,
  input  logic [HEAD_W-1:0] head_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              accept_o,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o
);

  logic [GB_SEQ_W-1:0] r_seq;
  logic [DATA_W-1:0]   r_res;
  logic [DATA_W-1:0]   r_data;
  logic                r_vld;

  logic [BLOCK_W-1:0]  w_blk;
  logic [2*DATA_W-1:0] w_cat;
  logic                w_flush;

  assign w_blk   = {data_i, head_i};
  assign w_flush = (r_seq == GB_SEQ_MAX);

  // New block lands just above the 2*seq pending residual bits; residual bits above
  // 2*seq are always zero, so an OR completes the concatenation.
  assign w_cat = ({{(2*DATA_W-BLOCK_W){1'b0}}, w_blk} << {r_seq, 1'b0})
               | {{DATA_W{1'b0}}, r_res};

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_seq  <= '0;
      r_res  <= '0;
      r_data <= '0;
      r_vld  <= 1'b0;
    end else begin
      r_vld <= valid_i;
      if (valid_i) begin
        if (w_flush) begin
          r_data <= r_res;
          r_res  <= '0;
          r_seq  <= '0;
        end else begin
          r_data <= w_cat[DATA_W-1:0];
          r_res  <= w_cat[2*DATA_W-1:DATA_W];
          r_seq  <= r_seq + 6'd1;
        end
      end
    end
  end

  assign accept_o = !w_flush;
  assign valid_o  = r_vld;
  assign data_o   = r_data;

endmodule

// File: tb/tb_gearbox_tx.sv
// Randomised scoreboard bench for gearbox_tx: blocks in, bit stream out, rebuilt into blocks.
module tb_gearbox_tx;
  import pcs_pkg::*;

  localparam int PERIOD = int'(GB_SEQ_MAX) + 1;

  logic              clk = 1'b0;
  logic              nreset;
  logic              valid_i;
  logic [HEAD_W-1:0] head_i;
  logic [DATA_W-1:0] data_i;
  logic              accept_o;
  logic              valid_o;
  logic [DATA_W-1:0] data_o;

  always #5 clk = ~clk;

  gearbox_tx dut (
    .clk      (clk),
    .nreset   (nreset),
    .valid_i  (valid_i),
    .head_i   (head_i),
    .data_i   (data_i),
    .accept_o (accept_o),
    .valid_o  (valid_o),
    .data_o   (data_o)
  );

  int                 n_chk   = 0;
  int                 n_pass  = 0;
  int                 ena_cnt = 0;
  int                 n_acc   = 0;
  logic               mon_en  = 1'b0;
  logic               exp_acc = 1'b1;
  logic               last_vi;
  logic [BLOCK_W-1:0] exp_blk[$];
  bit                 obits[$];
  logic [BLOCK_W-1:0] m_blk;
  logic [HEAD_W-1:0]  last_h;
  logic [DATA_W-1:0]  last_d;

  task automatic chk(input string nm, input logic [BLOCK_W-1:0] got, input logic [BLOCK_W-1:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", nm, got, exp);
  endtask

  // Expected valid_o is simply valid_i delayed by one clock.
  always @(posedge clk or negedge nreset) begin
    if (!nreset) last_vi <= 1'b0;
    else         last_vi <= valid_i;
  end

  // Monitor: serialise every valid word, rebuild 66-bit blocks, compare in order.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("valid_o", BLOCK_W'(valid_o), BLOCK_W'(last_vi));
      chk("accept_o", BLOCK_W'(accept_o), BLOCK_W'(exp_acc));
      if (valid_o === 1'b1) begin
        for (int i = 0; i < DATA_W; i++) obits.push_back(data_o[i]);
        while (obits.size() >= BLOCK_W) begin
          for (int i = 0; i < BLOCK_W; i++) m_blk[i] = obits.pop_front();
          if (exp_blk.size() == 0) begin
            n_chk++;
            $display("FAIL block_order: got %h, expected no pending block", m_blk);
          end else begin
            chk("block", m_blk, exp_blk.pop_front());
          end
        end
      end
    end
  end

  // Reference: enabled cycles repeat in periods of 33, the last one being the stall.
  task automatic drive(input logic vi, input logic [HEAD_W-1:0] h, input logic [DATA_W-1:0] d);
    logic acc;
    acc     = (ena_cnt % PERIOD) != (PERIOD - 1);
    valid_i = vi;
    head_i  = h;
    data_i  = d;
    exp_acc = acc;
    if (vi && acc) begin
      exp_blk.push_back({d, h});
      n_acc++;
      last_h = h;
      last_d = d;
    end
    if (vi) ena_cnt++;
    @(posedge clk);
    #1;
  endtask

  task automatic drive_rand(input logic vi);
    logic [DATA_W-1:0] d;
    logic [HEAD_W-1:0] h;
    d = {$urandom, $urandom};
    h = ($urandom_range(1) == 1) ? SYNC_CTRL : SYNC_DATA;
    drive(vi, h, d);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [DATA_W-1:0] d0;
    logic [DATA_W-1:0] saved_d;
    int                target;

    valid_i = 1'b0;
    head_i  = SYNC_DATA;
    data_i  = '0;
    nreset  = 1'b0;
    #2;
    chk("reset data_o", BLOCK_W'(data_o), '0);
    chk("reset valid_o", BLOCK_W'(valid_o), '0);
    chk("reset accept_o", BLOCK_W'(accept_o), BLOCK_W'(1'b1));
    @(posedge clk);
    #1;
    nreset = 1'b1;
    mon_en = 1'b1;

    // First block straight after reset
    d0 = 64'h0123_4567_89AB_CDEF;
    drive(1'b1, SYNC_DATA, d0);
    chk("first_word", BLOCK_W'(data_o), BLOCK_W'({d0[DATA_W-3:0], SYNC_DATA}));
    chk("first_valid", BLOCK_W'(valid_o), BLOCK_W'(1'b1));

    // Rest of the first period: 31 more blocks, then the stall
    for (int i = 0; i < 31; i++) drive_rand(1'b1);
    saved_d = last_d;
    chk("stall accept_o", BLOCK_W'(accept_o), '0);
    drive_rand(1'b1);
    chk("flush word", BLOCK_W'(data_o), BLOCK_W'(saved_d));
    drive_rand(1'b1);
    chk("header after wrap", BLOCK_W'(data_o[1:0]), BLOCK_W'(last_h));

    // Enable gap at seq=10
    while ((ena_cnt % PERIOD) != 10) drive_rand(1'b1);
    for (int i = 0; i < 3; i++) begin
      drive_rand(1'b0);
      chk("gap valid_o", BLOCK_W'(valid_o), '0);
      chk("gap accept_o", BLOCK_W'(accept_o), BLOCK_W'(1'b1));
    end
    for (int i = 0; i < 5; i++) drive_rand(1'b1);

    // Gap sitting on the stall point
    while ((ena_cnt % PERIOD) != (PERIOD - 1)) drive_rand(1'b1);
    for (int i = 0; i < 2; i++) begin
      drive_rand(1'b0);
      chk("stall gap accept_o", BLOCK_W'(accept_o), '0);
      chk("stall gap valid_o", BLOCK_W'(valid_o), '0);
    end
    saved_d = last_d;
    drive_rand(1'b1);
    chk("stall gap flush", BLOCK_W'(data_o), BLOCK_W'(saved_d));
    drive_rand(1'b1);

    // Long random stream with ~1 in 6 enable gaps
    target = n_acc + 2000;
    for (int c = 0; c < 5000 && n_acc < target; c++)
      drive_rand($urandom_range(5) != 0);
    chk("random blocks issued", BLOCK_W'(n_acc >= target), BLOCK_W'(1'b1));

    // Reset mid-sequence at seq=20
    while ((ena_cnt % PERIOD) != 20) drive_rand(1'b1);
    valid_i = 1'b0;
    mon_en  = 1'b0;
    #2;
    nreset = 1'b0;
    #1;
    chk("midreset data_o", BLOCK_W'(data_o), '0);
    chk("midreset valid_o", BLOCK_W'(valid_o), '0);
    chk("midreset accept_o", BLOCK_W'(accept_o), BLOCK_W'(1'b1));
    exp_blk.delete();
    obits.delete();
    ena_cnt = 0;
    exp_acc = 1'b1;
    @(posedge clk);
    #2;
    nreset = 1'b1;
    @(posedge clk);
    #1;
    mon_en = 1'b1;
    drive(1'b1, SYNC_CTRL, {$urandom, $urandom});
    chk("restart header", BLOCK_W'(data_o[1:0]), BLOCK_W'(SYNC_CTRL));
    for (int i = 0; i < 40; i++) drive_rand($urandom_range(5) != 0);

    for (int i = 0; i < 3; i++) drive_rand(1'b0);
    mon_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
